// File: rtl/sw_input_port_if.sv
// CPU data-bus view of the switch input port.
// Define SW_IRQ_EN to carry the interrupt line.
interface sw_input_port_if;
  logic [15:0] addr;
  logic        re;
  logic        we;
  logic [15:0] wdata;
  logic [15:0] rdata;
`ifdef SW_IRQ_EN
  logic        irq;
`endif

  modport master (
    output addr, re, we, wdata,
`ifdef SW_IRQ_EN
    input  irq,
`endif
    input  rdata
  );

  modport slave (
    input  addr, re, we, wdata,
`ifdef SW_IRQ_EN
    output irq,
`endif
    output rdata
  );
endinterface

// File: rtl/sw_input_port.sv
// Synchronized, debounced switch port with sticky rise capture.
// Define SW_IRQ_EN to add the mask register and registered irq.
module sw_input_port #(
  parameter int          WIDTH           = 10,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [15:0] BASE_ADDR       = 16'hC001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] SW,
  sw_input_port_if.slave   bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] VAL_ADDR = BASE_ADDR;
  localparam logic [15:0] CAP_ADDR = BASE_ADDR + 16'd1;
`ifdef SW_IRQ_EN
  localparam logic [15:0] MSK_ADDR = BASE_ADDR + 16'd2;
`endif

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] cap_clr;
  logic             cap_wr;
`ifdef SW_IRQ_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;
  logic             msk_wr;
`endif
  logic             unused_wdata;

  // Bits of wdata above WIDTH have no effect.
  assign unused_wdata = ^bus.wdata;

  // Two-flop synchronizer for the asynchronous switches.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= SW;
      s2_q <= s1_q;
    end
  end

  // Per-bit counter of consecutive cycles s2 differs.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Capture set by rising stable bits wins over W1C.
  always_comb begin
    rise    = stable_d & ~stable_q;
    cap_wr  = bus.we && (bus.addr == CAP_ADDR);
    cap_clr = cap_wr ? bus.wdata[WIDTH-1:0] : '0;
    cap_d   = (cap_q & ~cap_clr) | rise;
  end

`ifdef SW_IRQ_EN
  // Mask write and interrupt from pre-edge state.
  always_comb begin
    msk_wr = bus.we && (bus.addr == MSK_ADDR);
    mask_d = msk_wr ? bus.wdata[WIDTH-1:0] : mask_q;
    irq_d  = |(cap_q & mask_q);
  end
`endif

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      cap_q    <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
`ifdef SW_IRQ_EN
      mask_q   <= '0;
      irq_q    <= 1'b0;
`endif
    end else begin
      stable_q <= stable_d;
      cap_q    <= cap_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
`ifdef SW_IRQ_EN
      mask_q   <= mask_d;
      irq_q    <= irq_d;
`endif
    end
  end

  // Read mux; idle value is zero so reads can be ORed.
  always_comb begin
    bus.rdata = 16'h0000;
    if (bus.re) begin
      unique case (bus.addr)
        VAL_ADDR: bus.rdata = 16'(stable_q);
        CAP_ADDR: bus.rdata = 16'(cap_q);
`ifdef SW_IRQ_EN
        MSK_ADDR: bus.rdata = 16'(mask_q);
`endif
        default:  bus.rdata = 16'h0000;
      endcase
    end
  end

`ifdef SW_IRQ_EN
  assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_sw_input_port.sv
// Randomized and directed bench for sw_input_port.
// Build with SW_IRQ_EN to exercise the mask and irq.
module tb_sw_input_port;
  localparam int W  = 10;
  localparam int DC = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] SW;
  int           checks;
  int           errors;

  sw_input_port_if bus ();

  sw_input_port #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC),
    .BASE_ADDR(16'hC001)
  ) dut (
    .clk(clk),
    .rst(rst),
    .SW(SW),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a switch is accepted once the last
  // DC synchronized samples all disagree with the stable value.
  logic [W-1:0]  m_s1, m_s2, m_stable, m_cap;
  logic [W-1:0]  m_mask, m_ns, m_rise, m_clr;
  logic          m_irq;
  logic [W-1:0]  hist [DC-1];
  logic [DC-1:0] win  [W];

  always_comb begin
    m_ns = m_stable;
    for (int i = 0; i < W; i++) begin
      win[i][0] = m_s2[i];
      for (int j = 1; j < DC; j++) begin
        win[i][j] = hist[j-1][i];
      end
      if (win[i] == {DC{~m_stable[i]}}) begin
        m_ns[i] = ~m_stable[i];
      end
    end
    m_rise = m_ns & ~m_stable;
    m_clr  = '0;
    if (bus.we && bus.addr == 16'hC002) begin
      m_clr = bus.wdata[W-1:0];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_s1     <= '0;
      m_s2     <= '0;
      m_stable <= '0;
      m_cap    <= '0;
      m_mask   <= '0;
      m_irq    <= 1'b0;
      for (int j = 0; j < DC-1; j++) begin
        hist[j] <= '0;
      end
    end else begin
      m_s1     <= SW;
      m_s2     <= m_s1;
      m_stable <= m_ns;
      m_cap    <= (m_cap & ~m_clr) | m_rise;
      m_irq    <= |(m_cap & m_mask);
      hist[0]  <= m_s2;
      for (int j = 1; j < DC-1; j++) begin
        hist[j] <= hist[j-1];
      end
`ifdef SW_IRQ_EN
      if (bus.we && bus.addr == 16'hC003) begin
        m_mask <= bus.wdata[W-1:0];
      end
`endif
    end
  end

  function automatic logic [15:0] exp_rdata();
    logic [15:0] r;
    r = 16'h0000;
    if (bus.re) begin
      if (bus.addr == 16'hC001) r = 16'(m_stable);
      if (bus.addr == 16'hC002) r = 16'(m_cap);
`ifdef SW_IRQ_EN
      if (bus.addr == 16'hC003) r = 16'(m_mask);
`endif
    end
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [15:0] a);
    bus.we   = 1'b0;
    bus.re   = 1'b1;
    bus.addr = a;
    #1;
  endtask

  task automatic wr(input logic [15:0] a,
                    input logic [15:0] d);
    bus.re    = 1'b0;
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.we    = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    SW        = '1;
    bus.re    = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 16'h0000;
    bus.wdata = 16'h0000;
    cyc(2);
    rd(16'hC001);
    checks++;
    if (bus.rdata !== 16'h0000) begin
      errors++;
      $display("FAIL rst_val got %h want 0000", bus.rdata);
    end
    rd(16'hC002);
    checks++;
    if (bus.rdata !== 16'h0000) begin
      errors++;
      $display("FAIL rst_cap got %h want 0000", bus.rdata);
    end
    rst = 1'b0;
    rd(16'hC001);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.rdata !== (k == 5 ? 16'h03FF : 16'h0000)) begin
        errors++;
        $display("FAIL latency edge %0d got %h", k, bus.rdata);
      end
    end
    rd(16'hC002);
    checks++;
    if (bus.rdata !== 16'h03FF) begin
      errors++;
      $display("FAIL init_cap got %h want 03ff", bus.rdata);
    end
  endtask

  task automatic test_glitch();
    SW = '0;
    cyc(8);
    wr(16'hC002, 16'hFFFF);
    rd(16'hC002);
    checks++;
    if (bus.rdata !== 16'h0000) begin
      errors++;
      $display("FAIL clr_all got %h want 0000", bus.rdata);
    end
    @(negedge clk);
    SW = 10'h001;
    cyc(3);
    SW = 10'h000;
    rd(16'hC001);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.rdata !== 16'h0000) begin
        errors++;
        $display("FAIL glitch_val got %h want 0000",
                 bus.rdata);
      end
    end
    rd(16'hC002);
    checks++;
    if (bus.rdata !== 16'h0000) begin
      errors++;
      $display("FAIL glitch_cap got %h want 0000", bus.rdata);
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    SW = 10'h005;
    cyc(8);
    rd(16'hC001);
    checks++;
    if (bus.rdata !== 16'h0005) begin
      errors++;
      $display("FAIL cap_val got %h want 0005", bus.rdata);
    end
    rd(16'hC002);
    checks++;
    if (bus.rdata !== 16'h0005) begin
      errors++;
      $display("FAIL cap_set got %h want 0005", bus.rdata);
    end
    wr(16'hC002, 16'h0001);
    rd(16'hC002);
    checks++;
    if (bus.rdata !== 16'h0004) begin
      errors++;
      $display("FAIL w1c got %h want 0004", bus.rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.rdata !== 16'h0004) begin
      errors++;
      $display("FAIL reread got %h want 0004", bus.rdata);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    SW = 10'h001;
    cyc(8);
    wr(16'hC002, 16'h0004);
    rd(16'hC002);
    checks++;
    if (bus.rdata !== 16'h0000) begin
      errors++;
      $display("FAIL pre_coll got %h want 0000", bus.rdata);
    end
    @(negedge clk);
    SW = 10'h005;
    cyc(5);
    rd(16'hC001);
    checks++;
    if (bus.rdata !== 16'h0001) begin
      errors++;
      $display("FAIL coll_pre got %h want 0001", bus.rdata);
    end
    wr(16'hC002, 16'h0004);
    rd(16'hC002);
    checks++;
    if (bus.rdata !== 16'h0004) begin
      errors++;
      $display("FAIL set_wins got %h want 0004", bus.rdata);
    end
    rd(16'hC001);
    checks++;
    if (bus.rdata !== 16'h0005) begin
      errors++;
      $display("FAIL coll_val got %h want 0005", bus.rdata);
    end
  endtask

  task automatic test_decode();
    logic [15:0] m3;
    rd(16'hC000);
    checks++;
    if (bus.rdata !== 16'h0000) begin
      errors++;
      $display("FAIL rd_c000 got %h want 0000", bus.rdata);
    end
    rd(16'hC005);
    checks++;
    if (bus.rdata !== 16'h0000) begin
      errors++;
      $display("FAIL rd_c005 got %h want 0000", bus.rdata);
    end
    bus.re   = 1'b0;
    bus.addr = 16'hC001;
    #1;
    checks++;
    if (bus.rdata !== 16'h0000) begin
      errors++;
      $display("FAIL re_low got %h want 0000", bus.rdata);
    end
    wr(16'hC001, 16'hFFFF);
    rd(16'hC001);
    checks++;
    if (bus.rdata !== 16'h0005) begin
      errors++;
      $display("FAIL wr_val got %h want 0005", bus.rdata);
    end
    wr(16'hC003, 16'hFFFF);
    rd(16'hC003);
`ifdef SW_IRQ_EN
    m3 = 16'h03FF;
`else
    m3 = 16'h0000;
`endif
    checks++;
    if (bus.rdata !== m3) begin
      errors++;
      $display("FAIL rd_c003 got %h want %h", bus.rdata, m3);
    end
    wr(16'hC003, 16'h0000);
  endtask

`ifdef SW_IRQ_EN
  task automatic test_irq();
    @(negedge clk);
    SW = 10'h000;
    cyc(8);
    wr(16'hC002, 16'hFFFF);
    wr(16'hC003, 16'h0002);
    rd(16'hC003);
    checks++;
    if (bus.rdata !== 16'h0002) begin
      errors++;
      $display("FAIL mask_rd got %h want 0002", bus.rdata);
    end
    @(negedge clk);
    SW = 10'h002;
    rd(16'hC002);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.irq !== 1'b0) begin
        errors++;
        $display("FAIL irq_early edge %0d got %b", k, bus.irq);
      end
    end
    checks++;
    if (bus.rdata !== 16'h0002) begin
      errors++;
      $display("FAIL irq_cap got %h want 0002", bus.rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set got %b want 1", bus.irq);
    end
    wr(16'hC002, 16'h0002);
    #1;
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_hold got %b want 1", bus.irq);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clr got %b want 0", bus.irq);
    end
    SW = 10'h00A;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.irq !== 1'b0) begin
        errors++;
        $display("FAIL irq_masked got %b want 0", bus.irq);
      end
    end
    rd(16'hC002);
    checks++;
    if (bus.rdata !== 16'h0008) begin
      errors++;
      $display("FAIL cap3 got %h want 0008", bus.rdata);
    end
  endtask
`endif

  task automatic test_random();
    int hold;
    hold = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (hold == 0) begin
        SW   = W'($urandom);
        hold = $urandom_range(1, 7);
      end
      hold--;
      bus.re    = ($urandom_range(0, 3) != 0);
      bus.we    = ($urandom_range(0, 5) == 0);
      bus.addr  = 16'hC000 + 16'($urandom_range(0, 4));
      bus.wdata = 16'($urandom);
      #1;
      checks++;
      if (bus.rdata !== exp_rdata()) begin
        errors++;
        $display("FAIL rand_rd @%h cyc %0d got %h want %h",
                 bus.addr, n, bus.rdata, exp_rdata());
      end
`ifdef SW_IRQ_EN
      checks++;
      if (bus.irq !== m_irq) begin
        errors++;
        $display("FAIL rand_irq cyc %0d got %b want %b",
                 n, bus.irq, m_irq);
      end
`endif
    end
    bus.re = 1'b0;
    bus.we = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_glitch();
    test_capture();
    test_collision();
    test_decode();
`ifdef SW_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sw_input_port.md
Name: sw_input_port

Overview:
- Memory-mapped switch input peripheral on the CPU data bus, upstream of the CPU read path.
- Synchronizes and debounces the board slide switches, then presents the stable value for CPU reads.
- Latches rising edges in a sticky capture register. The CPU clears captured bits with write-1-to-clear.
- Outputs 16'h0000 when not selected, so the top level can OR rdata with other peripherals.

Parameters:
- WIDTH, 10, number of switch inputs (1..16).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a switch change is accepted (>=2). Sim uses 4.
- BASE_ADDR, 16'hC001, address of the debounced-value register. Capture register is at BASE_ADDR+1. Mask register (optional) is at BASE_ADDR+2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- SW  input  WIDTH  raw asynchronous switch levels.
- addr  input  16  CPU bus address.
- re  input  1  CPU read enable.
- we  input  1  CPU write enable.
- wdata  input  16  CPU write data.
- rdata  output  16  read data, combinational.
- irq  output  1  interrupt request; present only with SW_IRQ_EN.

Behaviour:
- Reset: all of the following clear to 0 on the first rising clk edge with rst=1: sync stages, stable value, debounce counters, capture register, mask register, irq. rst has priority over every other event.
- Synchronizer: two flops per bit, SW -> s1 -> s2. No other logic reads SW.
- Debounce, per bit, independent counter of width $clog2(DEBOUNCE_CYCLES):
  - s2 == stable: counter <= 0.
  - s2 != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
  - Glitch shorter than DEBOUNCE_CYCLES cycles at s2: stable unchanged, counter returns to 0.
- Latency: a clean SW change set up before edge 0 is visible in stable after edge 2+DEBOUNCE_CYCLES-1. It is readable in the cycle that follows.
- Edge capture: cap[i] sets on a cycle where stable[i] goes 0->1. Falling edges are ignored. Bits are sticky.
- Clearing capture: a write with addr==BASE_ADDR+1 and we=1 clears cap[i] wherever wdata[i]=1.
- Set/clear collision: if a set and a clear hit the same bit in the same cycle, set wins.
- Writes to BASE_ADDR: ignored.
- wdata bits >= WIDTH: ignored.
- Read decode, combinational:
  - re && addr==BASE_ADDR -> rdata = stable, zero-extended to 16 bits.
  - re && addr==BASE_ADDR+1 -> rdata = cap, zero-extended.
  - Any other address, or re=0 -> rdata = 16'h0000.
- Read side effects: none. Reading does not clear capture.
- Simultaneous re and we on a register: read returns the pre-edge value; the write takes effect at the edge.

Optional Feature:
- Macro: SW_IRQ_EN.
- Defined:
  - Adds a WIDTH-bit mask register at BASE_ADDR+2, written with we and wdata[WIDTH-1:0], readable with re.
  - irq is registered: irq <= |(cap & mask) each cycle. It asserts one cycle after a capture bit and its mask bit are both 1.
  - irq deasserts one cycle after the clearing write.
- Not defined:
  - No irq port and no mask register.
  - BASE_ADDR+2 reads 16'h0000; writes to it are ignored.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=10, BASE_ADDR=16'hC001):
- Hold rst=1 for 2 cycles with SW=10'h3FF -> rdata=0 at C001/C002. After release, C001 reads 16'h03FF exactly 5 edges after SW becomes valid.
- SW[0] goes high for 3 cycles, then low -> C001 stays 16'h0000; C002 stays 0.
- SW=10'h005 held clean -> C001=16'h0005 and C002=16'h0005. Write 16'h0001 to C002 -> C002=16'h0004. Read C002 again -> still 16'h0004.
- Write 16'h0004 to C002 in the same cycle stable[2] rises again -> C002 bit 2 remains 1 (set wins).
- Read C000 and C005 with re=1, and C001 with re=0 -> rdata=16'h0000 every time.
- SW_IRQ_EN defined: write 16'h0002 to C003, then drive SW[1] high clean -> irq=1 one cycle after cap[1] sets. Write 16'h0002 to C002 -> irq=0 on the next cycle. SW[3] edge with mask bit 3 clear -> irq stays 0.
